// File: rtl/mxint8_bd_sched.sv
// rtl/mxint8_bd_sched.sv - round-robin scheduler sharing one mxint8 broadcast converter
// Optional MXINT8_BD_SCHED_STATS_EN adds saturating conversion/stall/overflow counters.
`ifndef FLOAT32_WIDTH
`define FLOAT32_WIDTH 32
`endif
`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif

module mxint8_bd_sched #(
  parameter int NUM_REQ    = 4,
  parameter int BD_LATENCY = 1,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_REQ-1:0]                              i_req_valid,
  output logic [NUM_REQ-1:0]                              o_req_ready,
  input  logic [NUM_REQ*`FLOAT32_WIDTH-1:0]               i_req_float32,
  output logic [`FLOAT32_WIDTH-1:0]                       o_bd_float32,
  input  logic [`SCALE_WIDTH-1:0]                         i_bd_scale,
  input  logic [`BLOCK_SIZE*`MXINT8_ELEMENT_WIDTH-1:0]    i_bd_elements,
  input  logic                                            i_bd_overflow,
  output logic                                            o_res_valid,
  input  logic                                            i_res_ready,
  output logic [ID_W-1:0]                                 o_res_id,
  output logic [`SCALE_WIDTH-1:0]                         o_res_scale,
  output logic [`BLOCK_SIZE*`MXINT8_ELEMENT_WIDTH-1:0]    o_res_elements,
  output logic                                            o_res_overflow
`ifdef MXINT8_BD_SCHED_STATS_EN
  ,
  output logic [15:0]                                     o_stat_conv,
  output logic [15:0]                                     o_stat_stall,
  output logic [15:0]                                     o_stat_ovf
`endif
);

  localparam int FW    = `FLOAT32_WIDTH;
  localparam int LAT_W = (BD_LATENCY > 1) ? $clog2(BD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(BD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, HOLD = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, id_reg, grant_id, cand;
  logic            grant_vld, accept, conv_done, res_hs;
  logic [LAT_W-1:0] lat_cnt;

  // Walk downward so the candidate closest to rr_ptr is the one that sticks.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (i_req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign accept    = (state == IDLE) && grant_vld;
  assign conv_done = (state == CONVERT) && (lat_cnt == '0);
  assign res_hs    = (state == HOLD) && i_res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = CONVERT;
      CONVERT: if (conv_done) state_nxt = HOLD;
      HOLD:    if (i_res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is masked during reset so nothing looks accepted while state is forced.
  always_comb begin
    o_req_ready = '0;
    if (state == IDLE && grant_vld && !rst) o_req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      id_reg       <= '0;
      lat_cnt      <= '0;
      o_bd_float32 <= '0;
    end else if (accept) begin
      o_bd_float32 <= i_req_float32[int'(grant_id)*FW +: FW];
      id_reg       <= grant_id;
      rr_ptr       <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      lat_cnt      <= LAT_INIT;
    end else if (state == CONVERT && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_res_valid    <= 1'b0;
      o_res_id       <= '0;
      o_res_scale    <= '0;
      o_res_elements <= '0;
      o_res_overflow <= 1'b0;
    end else if (conv_done) begin
      o_res_valid    <= 1'b1;
      o_res_id       <= id_reg;
      o_res_scale    <= i_bd_scale;
      o_res_elements <= i_bd_elements;
      o_res_overflow <= i_bd_overflow;
    end else if (res_hs) begin
      o_res_valid <= 1'b0;
    end
  end

`ifdef MXINT8_BD_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_stat_conv  <= '0;
      o_stat_stall <= '0;
      o_stat_ovf   <= '0;
    end else begin
      if (res_hs && o_stat_conv != 16'hFFFF)
        o_stat_conv <= o_stat_conv + 16'd1;
      if (state == HOLD && !i_res_ready && o_stat_stall != 16'hFFFF)
        o_stat_stall <= o_stat_stall + 16'd1;
      if (res_hs && o_res_overflow && o_stat_ovf != 16'hFFFF)
        o_stat_ovf <= o_stat_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mxint8_bd_sched.sv
// tb/tb_mxint8_bd_sched.sv - directed self-checking bench for mxint8_bd_sched
module tb_mxint8_bd_sched;
  localparam int NR = 4;
  localparam int FW = 32;
  localparam int SW = 8;
  localparam int EW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  logic [NR-1:0]    rv1, rdy1, rv4, rdy4, exp_rdy;
  logic [NR*FW-1:0] rf1, rf4;
  logic [FW-1:0]    bd1, bd4;
  logic [SW-1:0]    bds1, bds4, sc1, sc4;
  logic [EW-1:0]    bde1, bde4, el1, el4, exp_el;
  logic             bdo1, bdo4, vld1, vld4, rr1, rr4, ov1, ov4;
  logic [1:0]       id1, id4;
  logic [FW-1:0]    p4 [0:2];
  logic [FW-1:0]    ops [0:3];
  logic [SW-1:0]    xs [0:3];
  logic [7:0]       xe [0:3];
`ifdef MXINT8_BD_SCHED_STATS_EN
  logic [15:0]      sconv1, sstall1, sovf1, sconv4, sstall4, sovf4;
`endif

  function automatic logic [SW-1:0] m_scale(input logic [FW-1:0] f);
    return f[30:23];
  endfunction
  function automatic logic [EW-1:0] m_elem(input logic [FW-1:0] f);
    return {32{f[31], 1'b1, f[22:17]}};
  endfunction
  function automatic logic m_ovf(input logic [FW-1:0] f);
    return (f[30:23] == 8'hFE) && (&f[22:16]);
  endfunction

  task automatic chk(input string tag, input logic ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $error("FAIL %s: observed mismatch expected match", tag);
    end
  endtask

  assign bds1 = m_scale(bd1);
  assign bde1 = m_elem(bd1);
  assign bdo1 = m_ovf(bd1);

  always @(posedge clk) begin
    p4[0] <= bd4;
    p4[1] <= p4[0];
    p4[2] <= p4[1];
  end
  assign bds4 = m_scale(p4[2]);
  assign bde4 = m_elem(p4[2]);
  assign bdo4 = m_ovf(p4[2]);

  mxint8_bd_sched #(.NUM_REQ(NR), .BD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req_valid(rv1), .o_req_ready(rdy1), .i_req_float32(rf1),
    .o_bd_float32(bd1), .i_bd_scale(bds1), .i_bd_elements(bde1), .i_bd_overflow(bdo1),
    .o_res_valid(vld1), .i_res_ready(rr1), .o_res_id(id1),
    .o_res_scale(sc1), .o_res_elements(el1), .o_res_overflow(ov1)
`ifdef MXINT8_BD_SCHED_STATS_EN
    , .o_stat_conv(sconv1), .o_stat_stall(sstall1), .o_stat_ovf(sovf1)
`endif
  );

  mxint8_bd_sched #(.NUM_REQ(NR), .BD_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst),
    .i_req_valid(rv4), .o_req_ready(rdy4), .i_req_float32(rf4),
    .o_bd_float32(bd4), .i_bd_scale(bds4), .i_bd_elements(bde4), .i_bd_overflow(bdo4),
    .o_res_valid(vld4), .i_res_ready(rr4), .o_res_id(id4),
    .o_res_scale(sc4), .o_res_elements(el4), .o_res_overflow(ov4)
`ifdef MXINT8_BD_SCHED_STATS_EN
    , .o_stat_conv(sconv4), .o_stat_stall(sstall4), .o_stat_ovf(sovf4)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rv1 = '0; rf1 = '0; rr1 = 1'b0;
    rv4 = '0; rf4 = '0; rr4 = 1'b0;
    ops[0] = 32'h3F800000; xs[0] = 8'h7F; xe[0] = 8'h40;
    ops[1] = 32'h40000000; xs[1] = 8'h80; xe[1] = 8'h40;
    ops[2] = 32'hC0400000; xs[2] = 8'h80; xe[2] = 8'hE0;
    ops[3] = 32'h3E000000; xs[3] = 8'h7C; xe[3] = 8'h40;

    rv1 = 4'b1111;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", rdy1 === 4'b0000);
    chk("rst_bd", bd1 === 32'h0);
    chk("rst_valid", vld1 === 1'b0);
    chk("rst_id", id1 === 2'd0);
    chk("rst_scale", sc1 === 8'h00);
    exp_el = '0;
    chk("rst_elem", el1 === exp_el);
    chk("rst_ovf", ov1 === 1'b0);
    chk("rst_valid4", vld4 === 1'b0);
    rv1 = '0;
    tick;
    rst = 1'b0;

    rf1[31:0] = 32'h3F800000; rv1 = 4'b0001; rr1 = 1'b1;
    #1;
    chk("t1_ready", rdy1 === 4'b0001);
    tick; rv1 = '0; #1;
    chk("t1_bd", bd1 === 32'h3F800000);
    chk("t1_novalid", vld1 === 1'b0);
    chk("t1_ready_conv", rdy1 === 4'b0000);
    tick; #1;
    chk("t1_valid", vld1 === 1'b1);
    chk("t1_id", id1 === 2'd0);
    chk("t1_scale", sc1 === 8'h7F);
    exp_el = {32{8'h40}};
    chk("t1_elem", el1 === exp_el);
    chk("t1_ovf", ov1 === 1'b0);
    tick; #1;
    chk("t1_valid_clr", vld1 === 1'b0);

    rst = 1'b1; #1; rst = 1'b0;
    rf1 = {ops[3], ops[2], ops[1], ops[0]}; rv1 = 4'b1111; rr1 = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      exp_rdy = 4'(1 << (n % 4));
      chk("t2_grant", rdy1 === exp_rdy);
      tick; #1;
      chk("t2_bd", bd1 === ops[n % 4]);
      tick; #1;
      chk("t2_valid", vld1 === 1'b1);
      chk("t2_id", id1 === 2'(n % 4));
      chk("t2_scale", sc1 === xs[n % 4]);
      exp_el = {32{xe[n % 4]}};
      chk("t2_elem", el1 === exp_el);
      tick; #1;
    end
    rv1 = '0;

    rf1[63:32] = 32'h7F7FFFFF; rv1 = 4'b0010; rr1 = 1'b0;
    #1;
    chk("t3_ready", rdy1 === 4'b0010);
    tick; #1;
    chk("t3_bd", bd1 === 32'h7F7FFFFF);
    tick; #1;
    exp_el = {32{8'h7F}};
    for (int s = 0; s < 5; s++) begin
      chk("t3_valid", vld1 === 1'b1);
      chk("t3_id", id1 === 2'd1);
      chk("t3_scale", sc1 === 8'hFE);
      chk("t3_elem", el1 === exp_el);
      chk("t3_ovf", ov1 === 1'b1);
      chk("t3_ready_hold", rdy1 === 4'b0000);
      tick; #1;
    end
    rr1 = 1'b1; #1;
    chk("t3_hs_valid", vld1 === 1'b1);
    chk("t3_hs_ready", rdy1 === 4'b0000);
    tick; #1;
    chk("t3_valid_clr", vld1 === 1'b0);
    chk("t3_ready_idle", rdy1 === 4'b0010);
    tick; rv1 = '0; #1;
    chk("t3_bd_again", bd1 === 32'h7F7FFFFF);
    tick; #1;
    chk("t3_valid2", vld1 === 1'b1);
    chk("t3_id2", id1 === 2'd1);
    tick; #1;
    chk("t3_valid2_clr", vld1 === 1'b0);
`ifdef MXINT8_BD_SCHED_STATS_EN
    chk("t3_stat_conv", sconv1 === 16'd7);
    chk("t3_stat_stall", sstall1 === 16'd5);
    chk("t3_stat_ovf", sovf1 === 16'd2);
`endif

    rv1 = 4'b1111; #1;
    chk("t4_ready", rdy1 === 4'b0100);
    tick; #1;
    chk("t4_bd", bd1 === 32'hC0400000);
    rst = 1'b1; #1;
    chk("t4_rst_bd", bd1 === 32'h0);
    chk("t4_rst_valid", vld1 === 1'b0);
    chk("t4_rst_ready", rdy1 === 4'b0000);
    chk("t4_rst_id", id1 === 2'd0);
    chk("t4_rst_scale", sc1 === 8'h00);
    exp_el = '0;
    chk("t4_rst_elem", el1 === exp_el);
    chk("t4_rst_ovf", ov1 === 1'b0);
    tick; rst = 1'b0; #1;
    chk("t4_ptr_zero", rdy1 === 4'b0001);
    rv1 = '0;
    for (int s = 0; s < 3; s++) begin
      tick; #1;
      chk("t4_no_valid", vld1 === 1'b0);
    end
`ifdef MXINT8_BD_SCHED_STATS_EN
    chk("t4_stat_conv_rst", sconv1 === 16'd0);
`endif

    rf4 = {32'h0, ops[3], ops[2], ops[0]};
    for (int c = 0; c < 3; c++) begin
      rv4 = 4'(1 << c);
      rr4 = (c == 1) ? 1'b0 : 1'b1;
      #1;
      exp_rdy = 4'(1 << c);
      chk("t5_ready", rdy4 === exp_rdy);
      tick; rv4 = '0; #1;
      for (int w = 0; w < 4; w++) begin
        chk("t5_wait", vld4 === 1'b0);
        tick; #1;
      end
      chk("t5_valid", vld4 === 1'b1);
      chk("t5_id", id4 === 2'(c));
      chk("t5_scale", sc4 === xs[(c == 0) ? 0 : c + 1]);
      exp_el = {32{xe[(c == 0) ? 0 : c + 1]}};
      chk("t5_elem", el4 === exp_el);
      if (c == 1) begin
        tick; #1;
        chk("t5_stall", vld4 === 1'b1);
        tick; #1;
        rr4 = 1'b1; #1;
        chk("t5_stall_end", vld4 === 1'b1);
      end
      tick; #1;
      chk("t5_valid_clr", vld4 === 1'b0);
    end
`ifdef MXINT8_BD_SCHED_STATS_EN
    chk("t5_stat_conv", sconv4 === 16'd3);
    chk("t5_stat_stall", sstall4 === 16'd2);
    chk("t5_stat_ovf", sovf4 === 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mxint8_bd_sched.md
Name: mxint8_bd_sched

Overview:
- Round-robin scheduler that shares one mxint8_broadcast converter among NUM_REQ requesters.
- Accepts a float32 from one requester at a time and drives it into the converter through a held register.
- Waits BD_LATENCY cycles, then captures scale, elements and overflow into a one-entry result buffer.
- Returns the result with the requester ID over a valid/ready handshake; sits between the ALU operand front-end and the broadcast converter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BD_LATENCY, 1, cycles the converter output needs to settle after o_bd_float32 changes (1..8).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  per-requester accept; at most one bit high (one-hot or zero).
- i_req_float32  in  NUM_REQ*`FLOAT32_WIDTH  packed request operands; requester k occupies slice k.
- o_bd_float32  out  `FLOAT32_WIDTH  registered operand to the converter.
- i_bd_scale  in  `SCALE_WIDTH  converter scale.
- i_bd_elements  in  `BLOCK_SIZE*`MXINT8_ELEMENT_WIDTH  converter elements, packed; element 0 in the LSBs.
- i_bd_overflow  in  1  converter overflow flag.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  result consumer ready.
- o_res_id  out  ID_W  ID of the requester that owns the result.
- o_res_scale  out  `SCALE_WIDTH  captured scale.
- o_res_elements  out  `BLOCK_SIZE*`MXINT8_ELEMENT_WIDTH  captured elements.
- o_res_overflow  out  1  captured overflow.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE, rr_ptr=0, lat_cnt=0.
  - o_bd_float32=0, o_req_ready=0, o_res_valid=0, o_res_id=0, o_res_scale=0, o_res_elements=0, o_res_overflow=0.
- FSM states: IDLE, CONVERT, HOLD.
- IDLE:
  - Grant g = first k with i_req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - o_req_ready[g]=1 combinationally; this is the only state in which o_req_ready is nonzero.
  - At the accept edge:
    - o_bd_float32 <= slice g; id_reg <= g.
    - rr_ptr <= (g+1) mod NUM_REQ.
    - lat_cnt <= BD_LATENCY-1; state <= CONVERT.
  - No valid request: stay in IDLE; rr_ptr unchanged.
- CONVERT:
  - lat_cnt decrements each cycle.
  - On the edge where lat_cnt==0:
    - Capture i_bd_scale, i_bd_elements and i_bd_overflow into the o_res_* registers.
    - o_res_id <= id_reg; o_res_valid <= 1; state <= HOLD.
- HOLD:
  - All o_res_* outputs stay stable while o_res_valid=1 and i_res_ready=0.
  - On o_res_valid & i_res_ready: o_res_valid <= 0; state <= IDLE.
  - No new accept occurs in the handshake cycle.
- Timing:
  - If the accept handshake occurs in cycle T, o_res_valid is high from cycle T+BD_LATENCY+1.
  - Peak throughput is one conversion per BD_LATENCY+2 cycles.
- o_bd_float32 holds the last accepted operand through CONVERT, HOLD and IDLE; it changes only on an accept.
- Requesters may deassert i_req_valid before being granted; no state is kept for ungranted requests.
- i_res_ready is ignored outside HOLD.
- Reset mid-CONVERT or mid-HOLD: the in-flight result is discarded and no o_res_valid pulse is produced.
- All arithmetic is done by the converter; this block only routes and registers.

Optional Feature:
- Macro: MXINT8_BD_SCHED_STATS_EN.
- Defined:
  - Adds o_stat_conv (16 bit): increments on every result handshake.
  - Adds o_stat_stall (16 bit): increments each HOLD cycle with i_res_ready=0.
  - Adds o_stat_ovf (16 bit): increments on each result handshake with o_res_overflow=1.
  - All three counters saturate at 0xFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request, BD_LATENCY=1: after reset, i_req_valid=4'b0001, i_req_float32[0]=32'h3F800000 (1.0). Expect o_req_ready=4'b0001 in cycle 0, o_bd_float32=32'h3F800000 from cycle 1, o_res_valid in cycle 2 with o_res_id=0, and scale/elements equal to the reference model for 1.0.
- All requesters active, i_res_ready=1: i_req_valid=4'b1111 held. Expect grant order 0,1,2,3,0, o_res_id following the same order, and one result every 3 cycles.
- Backpressure: i_res_ready=0 for 5 cycles in HOLD with i_req_valid=4'b0010. Expect o_res_* stable, o_req_ready=0 throughout, and acceptance only after the result handshake plus one IDLE cycle.
- Overflow: operand 32'h7F7FFFFF (max finite float). Expect o_res_overflow to equal the reference overflow flag and stay stable until the handshake.
- Reset mid-operation: assert rst during CONVERT. Expect all outputs 0 immediately, no o_res_valid afterwards, and rr_ptr=0, so the next 4'b1111 request grants requester 0.
- BD_LATENCY=4, with stats enabled: perform 3 conversions, one of them stalled 2 cycles. Expect a result 5 cycles after each accept, o_stat_conv=3 and o_stat_stall=2.
